// File: rtl/mem_copy_dma.sv
// mem_copy_dma: XRAM-to-XRAM copy/fill engine behind a 16-byte CPU register window.
// A copy moves data in chunks of up to DEPTH bytes through a local buffer: read a chunk,
// then write it back out. Fill mode skips the read phase and writes the FILL byte.
module mem_copy_dma #(
  parameter logic [15:0] BASE_ADDR = 16'hf9f0,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DW        = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        ack,
  output logic        in_addr_range,
  output logic [15:0] xram_addr,
  output logic [7:0]  xram_data_out,
  input  logic [7:0]  xram_data_in,
  input  logic        xram_ack,
  output logic        xram_stb,
  output logic        xram_wr,
  output logic        done_irq,
  output logic [1:0]  memwr_state,
  output logic [15:0] memwr_rdaddr,
  output logic [15:0] memwr_wraddr,
  output logic [15:0] memwr_len,
  output logic        memwr_step
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_WRITE = 2'b10,
    S_BAD   = 2'b11
  } state_e;

  localparam logic [16:0]   DEPTH_W  = 17'(DEPTH);
  localparam logic [15:0]   DEPTH_M1 = 16'(DEPTH - 1);
  localparam logic [DW-1:0] IDX_MAX  = DW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [15:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d, len_q, len_d;
  logic [7:0]    fill_q, fill_d;
  logic          fill_mode_q, fill_mode_d;
  logic          done_q, done_d, aborted_q, aborted_d, done_irq_q, done_irq_d;
  logic [15:0]   rd_cur_q, rd_cur_d, wr_cur_q, wr_cur_d, rem_q, rem_d;
  logic [DW-1:0] idx_q, idx_d;
  logic          buf_we;
  logic [7:0]    chunk_buf [DEPTH];

  // Register window decode; the unsigned difference also rejects addresses below the base.
  logic [15:0] addr_off;
  logic [3:0]  reg_off;
  logic        busy, reg_we, ctrl_we, cfg_we, abort_cmd, go_cmd;
  logic [15:0] chunk_m1;
  logic        read_last, write_last;

  assign addr_off      = addr - BASE_ADDR;
  assign reg_off       = addr_off[3:0];
  assign in_addr_range = (addr_off < 16'd16);
  assign ack           = stb && in_addr_range;
  assign busy          = (state_q != S_IDLE);
  assign reg_we        = stb && wr && in_addr_range;
  assign ctrl_we       = reg_we && (reg_off == 4'd0);
  assign cfg_we        = reg_we && !busy;
  assign abort_cmd     = ctrl_we && data_in[7];
  assign go_cmd        = ctrl_we && data_in[0];

  // remaining is constant during READ, so the read chunk end comes from min(DEPTH, remaining);
  // during WRITE remaining counts down, so the chunk ends at a full buffer or the last byte.
  assign chunk_m1   = ({1'b0, rem_q} >= DEPTH_W) ? DEPTH_M1 : (rem_q - 16'd1);
  assign read_last  = (16'(idx_q) == chunk_m1);
  assign write_last = (idx_q == IDX_MAX) || (rem_q == 16'd1);

  // State register and all control/datapath flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      len_q       <= '0;
      fill_q      <= '0;
      fill_mode_q <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      done_irq_q  <= 1'b0;
      rd_cur_q    <= '0;
      wr_cur_q    <= '0;
      rem_q       <= '0;
      idx_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      len_q       <= len_d;
      fill_q      <= fill_d;
      fill_mode_q <= fill_mode_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      done_irq_q  <= done_irq_d;
      rd_cur_q    <= rd_cur_d;
      wr_cur_q    <= wr_cur_d;
      rem_q       <= rem_d;
      idx_q       <= idx_d;
    end
  end

  // Chunk buffer captures read data.
  always_ff @(posedge clk) begin
    // NOTE: no reset on the buffer; its contents are always written before being read.
    if (buf_we) chunk_buf[idx_q] <= xram_data_in;
  end

  // Next-state and datapath updates: CPU config writes, go/abort, transfer sequencing.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    len_d       = len_q;
    fill_d      = fill_q;
    fill_mode_d = fill_mode_q;
    done_d      = done_q;
    aborted_d   = aborted_q;
    done_irq_d  = 1'b0;
    rd_cur_d    = rd_cur_q;
    wr_cur_d    = wr_cur_q;
    rem_d       = rem_q;
    idx_d       = idx_q;
    buf_we      = 1'b0;

    if (cfg_we) begin
      case (reg_off)
        4'd2:    rd_addr_d[7:0]  = data_in;
        4'd3:    rd_addr_d[15:8] = data_in;
        4'd4:    wr_addr_d[7:0]  = data_in;
        4'd5:    wr_addr_d[15:8] = data_in;
        4'd6:    len_d[7:0]      = data_in;
        4'd7:    len_d[15:8]     = data_in;
        4'd8:    fill_d          = data_in;
        default: ;
      endcase
    end

    if (abort_cmd) begin
      // Abort beats go and drops any ack arriving in the same cycle.
      aborted_d = 1'b1;
      state_d   = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go_cmd) begin
            if (len_q == 16'd0) begin
              done_d     = 1'b1;
              done_irq_d = 1'b1;
            end else begin
              done_d      = 1'b0;
              aborted_d   = 1'b0;
              rd_cur_d    = rd_addr_q;
              wr_cur_d    = wr_addr_q;
              rem_d       = len_q;
              idx_d       = '0;
              fill_mode_d = data_in[1];
              state_d     = data_in[1] ? S_WRITE : S_READ;
            end
          end
        end
        S_READ: begin
          if (xram_ack) begin
            buf_we   = 1'b1;
            rd_cur_d = rd_cur_q + 16'd1;
            idx_d    = idx_q + DW'(1);
            if (read_last) begin
              idx_d   = '0;
              state_d = S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (xram_ack) begin
            wr_cur_d = wr_cur_q + 16'd1;
            idx_d    = idx_q + DW'(1);
            rem_d    = rem_q - 16'd1;
            if (write_last) begin
              idx_d = '0;
              if (rem_q == 16'd1) begin
                state_d    = S_IDLE;
                done_d     = 1'b1;
                done_irq_d = 1'b1;
              end else if (!fill_mode_q) begin
                state_d = S_READ;
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // XRAM bus outputs decoded from the current state.
  always_comb begin
    xram_stb      = 1'b0;
    xram_wr       = 1'b0;
    xram_addr     = '0;
    xram_data_out = '0;
    case (state_q)
      S_READ: begin
        xram_stb  = 1'b1;
        xram_addr = rd_cur_q;
      end
      S_WRITE: begin
        xram_stb      = 1'b1;
        xram_wr       = 1'b1;
        xram_addr     = wr_cur_q;
        xram_data_out = fill_mode_q ? fill_q : chunk_buf[idx_q];
      end
      default: ;
    endcase
  end

  // CPU read mux; CTRL and unmapped offsets read as zero.
  always_comb begin
    data_out = '0;
    if (in_addr_range) begin
      case (reg_off)
        4'd1:    data_out = {4'b0, aborted_q, done_q, state_q};
        4'd2:    data_out = rd_addr_q[7:0];
        4'd3:    data_out = rd_addr_q[15:8];
        4'd4:    data_out = wr_addr_q[7:0];
        4'd5:    data_out = wr_addr_q[15:8];
        4'd6:    data_out = len_q[7:0];
        4'd7:    data_out = len_q[15:8];
        4'd8:    data_out = fill_q;
        default: data_out = '0;
      endcase
    end
  end

  assign done_irq     = done_irq_q;
  assign memwr_state  = state_q;
  assign memwr_rdaddr = rd_addr_q;
  assign memwr_wraddr = wr_addr_q;
  assign memwr_len    = len_q;
  assign memwr_step   = (state_d != state_q);

endmodule

// File: tb/tb_mem_copy_dma.sv
// Testbench for mem_copy_dma: register-window vectors plus directed copy/fill/abort/reset sequences
// against a 64 KB XRAM model with optional random ack stalls.
module tb_mem_copy_dma;

  localparam logic [15:0] B = 16'hf9f0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stb = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  data_in = '0;
  logic [7:0]  data_out;
  logic        ack, in_addr_range;
  logic [15:0] xram_addr;
  logic [7:0]  xram_data_out;
  logic [7:0]  xram_data_in = '0;
  logic        xram_ack = 1'b0;
  logic        xram_stb, xram_wr, done_irq, memwr_step;
  logic [1:0]  memwr_state;
  logic [15:0] memwr_rdaddr, memwr_wraddr, memwr_len;

  mem_copy_dma dut (
    .clk(clk), .rst(rst), .stb(stb), .wr(wr), .addr(addr), .data_in(data_in),
    .data_out(data_out), .ack(ack), .in_addr_range(in_addr_range),
    .xram_addr(xram_addr), .xram_data_out(xram_data_out), .xram_data_in(xram_data_in),
    .xram_ack(xram_ack), .xram_stb(xram_stb), .xram_wr(xram_wr), .done_irq(done_irq),
    .memwr_state(memwr_state), .memwr_rdaddr(memwr_rdaddr), .memwr_wraddr(memwr_wraddr),
    .memwr_len(memwr_len), .memwr_step(memwr_step)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] xmem [65536];
  logic       stall = 1'b0;
  int         irq_cnt = 0;
  int         rw_trans = 0;
  logic       saw_read = 1'b0;
  logic [1:0] prev_state = 2'b00;

  // XRAM model: response driven mid-cycle, writes committed on the active edge.
  always @(negedge clk) begin
    xram_data_in = xmem[xram_addr];
    xram_ack     = xram_stb && (!stall || ($urandom_range(0, 1) == 1));
  end

  always @(posedge clk) begin
    if (xram_stb && xram_ack && xram_wr) xmem[xram_addr] = xram_data_out;
  end

  // Event monitor: done pulses, READ visits and READ->WRITE transitions.
  always @(negedge clk) begin
    if (rst) begin
      if (done_irq) irq_cnt++;
      if (memwr_state == 2'b01) saw_read = 1'b1;
      if (prev_state == 2'b01 && memwr_state == 2'b10) rw_trans++;
      prev_state = memwr_state;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    stb = 1'b1; wr = 1'b1; addr = a; data_in = d;
    @(posedge clk);
    #1;
    stb = 1'b0; wr = 1'b0;
  endtask

  task automatic cpu_rd(input logic [15:0] a, output logic [7:0] d, output logic k);
    @(negedge clk);
    stb = 1'b1; wr = 1'b0; addr = a;
    #1;
    d = data_out;
    k = ack;
    @(posedge clk);
    #1;
    stb = 1'b0;
  endtask

  task automatic program_regs(input logic [15:0] rd_a, input logic [15:0] wr_a,
                              input logic [15:0] len);
    cpu_wr(B + 16'd2, rd_a[7:0]);
    cpu_wr(B + 16'd3, rd_a[15:8]);
    cpu_wr(B + 16'd4, wr_a[7:0]);
    cpu_wr(B + 16'd5, wr_a[15:8]);
    cpu_wr(B + 16'd6, len[7:0]);
    cpu_wr(B + 16'd7, len[15:8]);
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget, input string name);
    int n;
    n = 0;
    while (memwr_state != st && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (memwr_state != st) check({name, " timeout"}, 32'(memwr_state), 32'(st));
  endtask

  task automatic clear_mon();
    irq_cnt = 0; rw_trans = 0; saw_read = 1'b0;
  endtask

  typedef struct {
    logic        is_wr;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  exp_d;
    logic        exp_ack;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [7:0] rd;
    logic       k;
    int         bad;

    for (int i = 0; i < 65536; i++) xmem[i] = 8'h00;
    for (int i = 0; i < 5; i++) xmem[16'h1000 + 16'(i)] = 8'h30 + 8'(i);
    for (int i = 0; i < 40; i++) xmem[16'h3000 + 16'(i)] = 8'(i * 7 + 3);
    for (int i = 0; i < 20; i++) xmem[16'h5000 + 16'(i)] = 8'(i) ^ 8'h5c;

    // Register window vectors: writes check ack, reads check data and ack.
    vecs.push_back('{1'b1, 16'hf9f2, 8'h00, 8'h00, 1'b1});
    vecs.push_back('{1'b1, 16'hf9f3, 8'h10, 8'h00, 1'b1});
    vecs.push_back('{1'b1, 16'hf9f4, 8'h00, 8'h00, 1'b1});
    vecs.push_back('{1'b1, 16'hf9f5, 8'h20, 8'h00, 1'b1});
    vecs.push_back('{1'b1, 16'hf9f6, 8'h05, 8'h00, 1'b1});
    vecs.push_back('{1'b1, 16'hf9f7, 8'h00, 8'h00, 1'b1});
    vecs.push_back('{1'b1, 16'hf9f8, 8'h5a, 8'h00, 1'b1});
    vecs.push_back('{1'b1, 16'hf9fc, 8'h77, 8'h00, 1'b1});
    vecs.push_back('{1'b1, 16'hfa00, 8'h77, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 16'hf9f2, 8'h00, 8'h00, 1'b1});
    vecs.push_back('{1'b0, 16'hf9f3, 8'h00, 8'h10, 1'b1});
    vecs.push_back('{1'b0, 16'hf9f5, 8'h00, 8'h20, 1'b1});
    vecs.push_back('{1'b0, 16'hf9f6, 8'h00, 8'h05, 1'b1});
    vecs.push_back('{1'b0, 16'hf9f8, 8'h00, 8'h5a, 1'b1});
    vecs.push_back('{1'b0, 16'hf9f0, 8'h00, 8'h00, 1'b1});
    vecs.push_back('{1'b0, 16'hf9f1, 8'h00, 8'h00, 1'b1});
    vecs.push_back('{1'b0, 16'hf9fc, 8'h00, 8'h00, 1'b1});
    vecs.push_back('{1'b0, 16'hf9ff, 8'h00, 8'h00, 1'b1});
    vecs.push_back('{1'b0, 16'hfa00, 8'h00, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 16'hf9ef, 8'h00, 8'h00, 1'b0});

    repeat (3) @(negedge clk);
    check("reset state", 32'(memwr_state), 32'd0);
    check("reset xram_stb", 32'(xram_stb), 32'd0);
    check("reset done_irq", 32'(done_irq), 32'd0);
    check("reset len", 32'(memwr_len), 32'd0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) begin
        @(negedge clk);
        stb = 1'b1; wr = 1'b1; addr = vecs[i].a; data_in = vecs[i].d;
        #1;
        check($sformatf("vec%0d wr ack", i), 32'(ack), 32'(vecs[i].exp_ack));
        @(posedge clk);
        #1;
        stb = 1'b0; wr = 1'b0;
      end else begin
        cpu_rd(vecs[i].a, rd, k);
        check($sformatf("vec%0d rd data", i), 32'(rd), 32'(vecs[i].exp_d));
        check($sformatf("vec%0d rd ack", i), 32'(k), 32'(vecs[i].exp_ack));
      end
    end
    check("rdaddr reg", 32'(memwr_rdaddr), 32'h1000);
    check("wraddr reg", 32'(memwr_wraddr), 32'h2000);

    // 1: five-byte copy, zero-wait acks, one-cycle start latency.
    clear_mon();
    cpu_wr(B, 8'h01);
    check("t1 first stb", 32'(xram_stb), 32'd1);
    check("t1 first addr", 32'(xram_addr), 32'h1000);
    wait_state(2'b00, 100, "t1 idle");
    repeat (2) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 5; i++)
      if (xmem[16'h2000 + 16'(i)] !== 8'h30 + 8'(i)) bad++;
    check("t1 bytes bad", 32'(bad), 32'd0);
    check("t1 irq count", 32'(irq_cnt), 32'd1);
    cpu_rd(B + 16'd1, rd, k);
    check("t1 status", 32'(rd), 32'h04);
    check("t1 rdaddr kept", 32'(memwr_rdaddr), 32'h1000);

    // 2: forty bytes in 16/16/8 chunks.
    program_regs(16'h3000, 16'h4000, 16'd40);
    clear_mon();
    cpu_wr(B, 8'h01);
    wait_state(2'b00, 400, "t2 idle");
    repeat (2) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 40; i++)
      if (xmem[16'h4000 + 16'(i)] !== 8'(i * 7 + 3)) bad++;
    check("t2 bytes bad", 32'(bad), 32'd0);
    check("t2 read->write", 32'(rw_trans), 32'd3);
    check("t2 irq count", 32'(irq_cnt), 32'd1);

    // 3: fill across the address wrap.
    cpu_wr(B + 16'd8, 8'ha5);
    program_regs(16'h0000, 16'hfffe, 16'd4);
    clear_mon();
    cpu_wr(B, 8'h03);
    wait_state(2'b00, 100, "t3 idle");
    repeat (2) @(negedge clk);
    check("t3 fffe", 32'(xmem[16'hfffe]), 32'ha5);
    check("t3 ffff", 32'(xmem[16'hffff]), 32'ha5);
    check("t3 0000", 32'(xmem[16'h0000]), 32'ha5);
    check("t3 0001", 32'(xmem[16'h0001]), 32'ha5);
    check("t3 0002 untouched", 32'(xmem[16'h0002]), 32'h00);
    check("t3 fffd untouched", 32'(xmem[16'hfffd]), 32'h00);
    check("t3 no read", 32'(saw_read), 32'd0);
    check("t3 irq count", 32'(irq_cnt), 32'd1);

    // 4: abort during READ, then restart.
    program_regs(16'h5000, 16'h6000, 16'd20);
    clear_mon();
    cpu_wr(B, 8'h01);
    cpu_wr(B, 8'h80);
    check("t4 idle after abort", 32'(memwr_state), 32'd0);
    repeat (3) @(negedge clk);
    cpu_rd(B + 16'd1, rd, k);
    check("t4 status", 32'(rd), 32'h08);
    check("t4 irq count", 32'(irq_cnt), 32'd0);
    check("t4 no write", 32'(xmem[16'h6000]), 32'h00);
    cpu_wr(B, 8'h01);
    wait_state(2'b00, 200, "t4 idle");
    repeat (2) @(negedge clk);
    check("t4 restart last", 32'(xmem[16'h6013]), 32'(8'd19 ^ 8'h5c));
    cpu_rd(B + 16'd1, rd, k);
    check("t4 restart status", 32'(rd), 32'h04);

    // 4b: go and abort together in IDLE.
    cpu_wr(B, 8'h81);
    check("t4b no start", 32'(memwr_state), 32'd0);
    cpu_rd(B + 16'd1, rd, k);
    check("t4b status", 32'(rd), 32'h0c);

    // 5: config writes ignored while busy; live STATUS.
    program_regs(16'h3000, 16'h7000, 16'd40);
    cpu_wr(B, 8'h01);
    cpu_wr(B + 16'd6, 8'h03);
    check("t5 len kept", 32'(memwr_len), 32'd40);
    cpu_rd(B + 16'd1, rd, k);
    check("t5 live status", 32'(rd), 32'h01);
    wait_state(2'b00, 400, "t5 idle");
    repeat (2) @(negedge clk);
    check("t5 last byte", 32'(xmem[16'h7027]), 32'(8'(39 * 7 + 3)));
    check("t5 len after", 32'(memwr_len), 32'd40);

    // 6: reset during WRITE with stalls, then a zero-length go.
    stall = 1'b1;
    program_regs(16'h3000, 16'h8000, 16'd40);
    cpu_wr(B, 8'h01);
    wait_state(2'b10, 400, "t6 write");
    #2 rst = 1'b0;
    #1;
    check("t6 rst state", 32'(memwr_state), 32'd0);
    check("t6 rst stb", 32'(xram_stb), 32'd0);
    check("t6 rst xaddr", 32'(xram_addr), 32'd0);
    check("t6 rst rdaddr", 32'(memwr_rdaddr), 32'd0);
    check("t6 rst wraddr", 32'(memwr_wraddr), 32'd0);
    check("t6 rst len", 32'(memwr_len), 32'd0);
    check("t6 rst irq", 32'(done_irq), 32'd0);
    cpu_rd(B + 16'd1, rd, k);
    check("t6 rst status", 32'(rd), 32'h00);
    cpu_rd(B + 16'd8, rd, k);
    check("t6 rst fill", 32'(rd), 32'h00);
    @(negedge clk);
    rst = 1'b1;
    stall = 1'b0;
    clear_mon();
    cpu_wr(B, 8'h01);
    check("t6 zero-len state", 32'(memwr_state), 32'd0);
    check("t6 zero-len irq", 32'(done_irq), 32'd1);
    repeat (2) @(negedge clk);
    check("t6 irq count", 32'(irq_cnt), 32'd1);
    cpu_rd(B + 16'd1, rd, k);
    check("t6 status", 32'(rd), 32'h04);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
